// File: rtl/dsd_mod.sv
// dsd_mod: PCM to 1-bit DSD second-order sigma-delta modulator with a one-entry sample buffer.
// Define DSD_DITHER_EN to add LFSR dither (+/-1) ahead of the 1-bit quantizer.
`ifndef PCM_QUANT
`define PCM_QUANT 8
`endif

module dsd_mod #(
    parameter int unsigned PCM_W = `PCM_QUANT,
    parameter int unsigned OSR   = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [PCM_W-1:0] pcm_in,
    input  logic                    pcm_valid,
    output logic                    pcm_ready,
    input  logic                    dsd_en,
    output logic                    dsd_out,
    output logic                    underrun
);

    localparam int unsigned IW = PCM_W + 4;
    localparam int unsigned EW = PCM_W + 6;
    localparam int unsigned CW = (OSR > 1) ? $clog2(OSR) : 1;

    localparam logic signed [EW-1:0] FS_E  = EW'((1 << (PCM_W - 1)) - 1);
    localparam logic signed [EW-1:0] I_MAX = EW'((1 << (IW - 1)) - 1);
    localparam logic signed [EW-1:0] I_MIN = EW'(-(1 << (IW - 1)));

    typedef enum logic [1:0] {StIdle, StRun, StStarved} state_e;

    state_e                  state_q;
    logic [CW-1:0]           cnt_q;
    logic                    full_q;
    logic signed [PCM_W-1:0] hold_q;
    logic signed [PCM_W-1:0] x_q;
    logic signed [IW-1:0]    i1_q, i2_q;
    logic signed [IW-1:0]    i1_d, i2_d;
    logic                    dsd_q;
    logic                    underrun_q;

    logic                    accept;
    logic                    boundary;
    logic                    bit_d;
    logic signed [EW-1:0]    q_in;
    logic signed [EW-1:0]    fb;

    function automatic logic signed [IW-1:0] sat(input logic signed [EW-1:0] v);
        if (v > I_MAX) begin
            return I_MAX[IW-1:0];
        end else if (v < I_MIN) begin
            return I_MIN[IW-1:0];
        end
        return v[IW-1:0];
    endfunction

    assign accept   = pcm_valid && !full_q;
    assign boundary = dsd_en && (cnt_q == CW'(OSR - 1));

`ifdef DSD_DITHER_EN
    localparam logic signed [EW-1:0] ONE = EW'(1);
    logic [15:0] lfsr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= 16'hACE1;
        end else if (dsd_en) begin
            lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        end
    end

    // Dither only perturbs the decision; integrators still see the undithered feedback.
    assign q_in = EW'(i2_q) + (lfsr_q[0] ? ONE : -ONE);
`else
    assign q_in = EW'(i2_q);
`endif

    assign bit_d = ~q_in[EW-1];

    always_comb begin
        fb   = bit_d ? FS_E : -FS_E;
        i1_d = sat(EW'(i1_q) + EW'(x_q) - fb);
        i2_d = sat(EW'(i2_q) + EW'(i1_q) - fb);
    end

    // Accept needs an empty buffer and a drain needs a full one, so they never collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            full_q     <= 1'b0;
            hold_q     <= '0;
            x_q        <= '0;
            i1_q       <= '0;
            i2_q       <= '0;
            dsd_q      <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= 1'b0;
            if (dsd_en) begin
                cnt_q <= boundary ? '0 : cnt_q + 1'b1;
                i1_q  <= i1_d;
                i2_q  <= i2_d;
                dsd_q <= bit_d;
            end
            if (accept) begin
                hold_q <= pcm_in;
                full_q <= 1'b1;
            end
            if (boundary) begin
                if (full_q) begin
                    x_q     <= hold_q;
                    full_q  <= 1'b0;
                    state_q <= StRun;
                end else if (state_q == StRun) begin
                    underrun_q <= 1'b1;
                    state_q    <= StStarved;
                end
            end
        end
    end

    assign pcm_ready = !full_q;
    assign dsd_out   = dsd_q;
    assign underrun  = underrun_q;

endmodule
